// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel hex text path (transmit and receive sides).
//   pixel_t          : packed 24-bit RGB pixel, r in the top byte.
//   tx_state_e       : encoder FSM states.
//   nibble_to_ascii  : 4-bit value to ASCII hex digit, case selectable.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam logic [7:0] HEX_LC_BASE    = 8'h61;
    localparam logic [7:0] HEX_UC_BASE    = 8'h41;
    localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StSep
    } tx_state_e;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                   input logic       uppercase);
        logic [7:0] n8;
        n8 = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return HEX_DIGIT_BASE + n8;
        end
        return (uppercase ? HEX_UC_BASE : HEX_LC_BASE) + n8 - 8'd10;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for pixel words, shared by the hex transmitter and receiver.
// Ports:
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   push_i       : write data_i (ignored while full)
//   data_i       : write data
//   pop_i        : discard head entry (ignored while empty)
//   data_o       : head entry, valid while !empty_o
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    import pixel_pkg::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pixel_hex_tx.sv
// Serializes 24-bit RGB pixels into ASCII hex text: six digits (r hi/lo, g hi/lo, b hi/lo)
// optionally followed by a separator byte.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   pix_valid/pix_ready : input pixel handshake, ready = FIFO not full
//   r_in, g_in, b_in    : pixel colour channels
//   char_valid/ready    : output byte handshake (registered valid/data)
//   char_data           : ASCII byte
//   busy                : FIFO holds pixels or a pixel is being emitted
//   pix_count           : pixels fully transmitted, wraps at 16 bits
module pixel_hex_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          SEP_EN     = 1'b1,
    parameter logic [7:0]  SEP_CHAR   = 8'h0A,
    parameter bit          UPPERCASE  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        busy,
    output logic [15:0] pix_count
);
    import pixel_pkg::*;

    localparam logic [2:0] LastIdx = 3'd5;

    pixel_t    fifo_head;
    logic      fifo_full, fifo_empty, fifo_pop, fifo_push;

    tx_state_e   state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  char_data_q, char_data_d;
    logic [15:0] pix_count_q, pix_count_d;
    logic        hs, complete;

    // Ready depends only on the registered fill level, never on this cycle's pop.
    assign pix_ready = ~fifo_full;
    assign fifo_push = pix_valid & ~fifo_full;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  ({r_in, g_in, b_in}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign hs = char_valid_q & char_ready;

    // The current nibble is always shift_q[23:20]; each accepted digit shifts by four.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        char_valid_d = char_valid_q;
        char_data_d  = char_data_q;
        pix_count_d  = pix_count_q;
        fifo_pop     = 1'b0;
        complete     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    idx_d    = 3'd0;
                    state_d  = StEmit;
                end
            end
            StEmit: begin
                if (!char_valid_q) begin
                    // First cycle after leaving idle: present the leading digit.
                    char_valid_d = 1'b1;
                    char_data_d  = nibble_to_ascii(shift_q[23:20], UPPERCASE);
                end else if (hs) begin
                    if (idx_q == LastIdx) begin
                        if (SEP_EN) begin
                            state_d     = StSep;
                            char_data_d = SEP_CHAR;
                        end else begin
                            complete = 1'b1;
                        end
                    end else begin
                        idx_d       = idx_q + 3'd1;
                        shift_d     = shift_q << 4;
                        char_data_d = nibble_to_ascii(shift_q[19:16], UPPERCASE);
                    end
                end
            end
            StSep: begin
                if (hs) begin
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            pix_count_d = pix_count_q + 16'd1;
            if (!fifo_empty) begin
                // Chain straight into the next pixel so the stream has no bubble.
                fifo_pop     = 1'b1;
                shift_d      = fifo_head;
                idx_d        = 3'd0;
                state_d      = StEmit;
                char_valid_d = 1'b1;
                char_data_d  = nibble_to_ascii(fifo_head.r[7:4], UPPERCASE);
            end else begin
                state_d      = StIdle;
                char_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            idx_q        <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
            pix_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign pix_count  = pix_count_q;
    assign busy       = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_pixel_hex_tx.sv
module tb_pixel_hex_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        pix_valid, pix_ready, char_valid, char_ready, busy;
    logic [7:0]  r_in, g_in, b_in, char_data;
    logic [15:0] pix_count;

    logic        pix_valid2, pix_ready2, char_valid2, char_ready2, busy2;
    logic [7:0]  char_data2;
    logic [15:0] pix_count2;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_count = 0;
    bit          rnd_mode = 1'b0;

    logic [7:0]  rx_q[$];
    int          rx_cyc[$];
    logic [7:0]  rx2_q[$];
    int          rx2_cyc[$];
    logic [23:0] acc_q[$];

    typedef struct {
        logic [23:0] pix;
        string       text;
    } vec_t;

    always #5 clk = ~clk;

    pixel_hex_tx dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    pixel_hex_tx #(
        .SEP_EN    (1'b0),
        .UPPERCASE (1'b1)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid2),
        .pix_ready  (pix_ready2),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .char_valid (char_valid2),
        .char_ready (char_ready2),
        .char_data  (char_data2),
        .busy       (busy2),
        .pix_count  (pix_count2)
    );

    // Reference text for one pixel: hex digits via lookup table, optional newline.
    function automatic string pix_text(input logic [23:0] p, input bit uc, input bit sep);
        string dl;
        string du;
        string s;
        int    n;
        dl = "0123456789abcdef";
        du = "0123456789ABCDEF";
        s  = "";
        for (int k = 0; k < 6; k++) begin
            n = int'(p[23 - 4 * k -: 4]);
            s = {s, uc ? du.substr(n, n) : dl.substr(n, n)};
        end
        if (sep) s = {s, "\n"};
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // One clock: record handshakes seen before the edge, then check hold-under-stall.
    task automatic tick();
        bit         stall;
        logic [7:0] held;
        stall = char_valid && !char_ready && !rst;
        held  = char_data;
        if (!rst) begin
            if (pix_valid && pix_ready) acc_q.push_back({r_in, g_in, b_in});
            if (char_valid && char_ready) begin
                rx_q.push_back(char_data);
                rx_cyc.push_back(cyc);
            end
            if (char_valid2 && char_ready2) begin
                rx2_q.push_back(char_data2);
                rx2_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (stall && !rst) begin
            check("stall_valid_held", 32'(char_valid), 32'd1);
            check("stall_data_held", 32'(char_data), 32'(held));
        end
        if (rnd_mode) char_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_cyc.delete();
        rx2_q.delete();
        rx2_cyc.delete();
        acc_q.delete();
    endtask

    task automatic push_pixel(input bit which, input logic [23:0] p);
        {r_in, g_in, b_in} = p;
        if (which) pix_valid2 = 1'b1;
        else       pix_valid  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (which ? pix_ready2 : pix_ready) begin
                tick();
                pix_valid  = 1'b0;
                pix_valid2 = 1'b0;
                return;
            end
            tick();
        end
        pix_valid  = 1'b0;
        pix_valid2 = 1'b0;
        timeout("push_pixel");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || char_valid || busy2 || char_valid2) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timeout("drain");
    endtask

    task automatic wait_bytes(input int k);
        int n;
        n = 0;
        while (rx_q.size() < k && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("wait_bytes");
    endtask

    task automatic check_stream(input string name, input string exp, input bit which);
        int         n;
        logic [7:0] a;
        logic [7:0] e;
        n = which ? rx2_q.size() : rx_q.size();
        check({name, "_len"}, 32'(n), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < n; i++) begin
            e = exp[i];
            a = which ? rx2_q[i] : rx_q[i];
            check($sformatf("%s_byte%0d", name, i), 32'(a), 32'(e));
        end
    endtask

    initial begin
        vec_t        tbl[5];
        string       all;
        logic [23:0] p;
        logic [23:0] plist[6];

        tbl[0] = '{24'h000000, "000000\n"};
        tbl[1] = '{24'hFFFFFF, "ffffff\n"};
        tbl[2] = '{24'h09A0F0, "09a0f0\n"};
        tbl[3] = '{24'h12AB3F, "12ab3f\n"};
        tbl[4] = '{24'h0F1E2D, "0f1e2d\n"};

        pix_valid   = 1'b0;
        pix_valid2  = 1'b0;
        r_in        = '0;
        g_in        = '0;
        b_in        = '0;
        char_ready  = 1'b1;
        char_ready2 = 1'b1;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        check("rst_pix_ready", 32'(pix_ready), 32'd1);
        check("rst_char_valid", 32'(char_valid), 32'd0);
        check("rst_char_data", 32'(char_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_count", 32'(pix_count), 32'd0);
        check("rst2_char_valid", 32'(char_valid2), 32'd0);
        tick();

        // Single pixel with latency check
        clear_logs();
        pix_valid = 1'b1;
        {r_in, g_in, b_in} = 24'h12AB3F;
        check("t1_ready", 32'(pix_ready), 32'd1);
        tick();
        pix_valid = 1'b0;
        check("t1_valid_at_n", 32'(char_valid), 32'd0);
        check("t1_busy_at_n", 32'(busy), 32'd1);
        tick();
        check("t1_valid_at_n1", 32'(char_valid), 32'd0);
        tick();
        check("t1_valid_at_n2", 32'(char_valid), 32'd1);
        check("t1_data_at_n2", 32'(char_data), 32'h31);
        drain();
        check_stream("t1", "12ab3f\n", 1'b0);
        exp_count = 1;
        check("t1_pix_count", 32'(pix_count), 32'(exp_count));
        check("t1_busy_after", 32'(busy), 32'd0);

        // Table of back-to-back pixels: stream must be gapless
        clear_logs();
        all = "";
        for (int i = 0; i < 5; i++) begin
            push_pixel(1'b0, tbl[i].pix);
            all = {all, tbl[i].text};
        end
        drain();
        check_stream("t2", all, 1'b0);
        if (rx_cyc.size() == 35) check("t2_gapless", 32'(rx_cyc[34] - rx_cyc[0]), 32'd34);
        exp_count += 5;
        check("t2_pix_count", 32'(pix_count), 32'(exp_count));

        // Backpressure at the third byte while the FIFO fills
        clear_logs();
        push_pixel(1'b0, 24'h12AB3F);
        wait_bytes(2);
        char_ready = 1'b0;
        check("t3_stall_data", 32'(char_data), 32'h61);
        check("t3_stall_valid", 32'(char_valid), 32'd1);
        for (int i = 0; i < 6; i++) plist[i] = 24'($urandom);
        for (int i = 0; i < 4; i++) push_pixel(1'b0, plist[i]);
        pix_valid = 1'b1;
        {r_in, g_in, b_in} = plist[4];
        check("t3_full_ready", 32'(pix_ready), 32'd0);
        tick();
        check("t3_full_ready2", 32'(pix_ready), 32'd0);
        check("t3_stall_data_end", 32'(char_data), 32'h61);
        char_ready = 1'b1;
        push_pixel(1'b0, plist[4]);
        push_pixel(1'b0, plist[5]);
        drain();
        all = "12ab3f\n";
        for (int i = 0; i < 6; i++) all = {all, pix_text(plist[i], 1'b0, 1'b1)};
        check_stream("t3", all, 1'b0);
        exp_count += 7;
        check("t3_pix_count", 32'(pix_count), 32'(exp_count));

        // Uppercase, no separator, 6 cycles per pixel
        clear_logs();
        p = 24'($urandom);
        push_pixel(1'b1, 24'hABCDEF);
        push_pixel(1'b1, p);
        drain();
        check_stream("t4", {"ABCDEF", pix_text(p, 1'b1, 1'b0)}, 1'b1);
        if (rx2_cyc.size() == 12) check("t4_gapless", 32'(rx2_cyc[11] - rx2_cyc[0]), 32'd11);
        check("t4_pix_count", 32'(pix_count2), 32'd2);

        // Randomized traffic with random backpressure
        clear_logs();
        rnd_mode = 1'b1;
        for (int k = 0; k < 30; k++) begin
            push_pixel(1'b0, 24'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd_mode   = 1'b0;
        char_ready = 1'b1;
        drain();
        all = "";
        foreach (acc_q[i]) all = {all, pix_text(acc_q[i], 1'b0, 1'b1)};
        check("rnd_accepted", 32'(acc_q.size()), 32'd30);
        check_stream("rnd", all, 1'b0);
        exp_count += acc_q.size();
        check("rnd_pix_count", 32'(pix_count), 32'(exp_count & 16'hFFFF));

        // Reset in the middle of a pixel with more queued behind it
        clear_logs();
        push_pixel(1'b0, 24'hFEDCBA);
        push_pixel(1'b0, 24'($urandom));
        push_pixel(1'b0, 24'($urandom));
        wait_bytes(3);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(char_valid), 32'd0);
        check("t5_pix_count", 32'(pix_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_pix_ready", 32'(pix_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        push_pixel(1'b0, 24'h123456);
        drain();
        check_stream("t5_after", "123456\n", 1'b0);
        check("t5_after_count", 32'(pix_count), 32'd1);

        // Counter wrap from 0xFFFF
        force dut.pix_count_q = 16'hFFFF;
        tick();
        release dut.pix_count_q;
        tick();
        check("t6_preload", 32'(pix_count), 32'hFFFF);
        clear_logs();
        push_pixel(1'b0, 24'h00FF00);
        drain();
        check_stream("t6", "00ff00\n", 1'b0);
        check("t6_wrap", 32'(pix_count), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
